// File: rtl/ad5683_spi_rx_if.sv
// SPI write-only bus for the AD5683 DAC link: sclk, mosi and frame select sync_n.
// The master drives the pins; the responder only observes them.
interface ad5683_spi_rx_if;
  logic sclk;
  logic mosi;
  logic sync_n;

  modport master (output sclk, mosi, sync_n);
  modport slave  (input  sclk, mosi, sync_n);
endinterface

// File: rtl/ad5683_spi_rx.sv
// AD5683 SPI responder: oversamples the SPI pins on clk, collects 24-bit write frames
// and keeps the DAC register model (input, DAC and control registers).
module ad5683_spi_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BITS  = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ad5683_spi_rx_if.slave       spi,
  output logic [15:0]          input_reg,
  output logic [15:0]          dac_code,
  output logic [5:0]           ctrl_reg,
  output logic [3:0]           last_cmd,
  output logic                 frame_valid,
  output logic                 frame_err,
  output logic                 dac_upd
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [4:0] FRAME_CNT = 5'(FRAME_BITS);
  localparam logic [4:0] CNT_MAX   = 5'd31;

  localparam logic [3:0] CMD_WR_INPUT  = 4'b0001;
  localparam logic [3:0] CMD_LDAC      = 4'b0010;
  localparam logic [3:0] CMD_WR_UPDATE = 4'b0011;
  localparam logic [3:0] CMD_WR_CTRL   = 4'b0100;

  logic [SYNC_STAGES-1:0] sclk_q, mosi_q, sync_q;
  logic                   sclk_d, sync_d;
  logic                   sclk_s, mosi_s, sync_n_s;
  logic                   sclk_fall, sync_fall, sync_rise;

  state_t      state;
  logic [4:0]  cnt;
  logic [23:0] shift;
  logic [3:0]  cmd;
  logic [15:0] data;

  // NOTE: synchroniser flops reset to the bus idle levels so releasing reset
  // never manufactures a false sclk or sync_n edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q <= '0;
      mosi_q <= '0;
      sync_q <= '1;
      sclk_d <= 1'b0;
      sync_d <= 1'b1;
    end else begin
      sclk_q <= {sclk_q[SYNC_STAGES-2:0], spi.sclk};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], spi.mosi};
      sync_q <= {sync_q[SYNC_STAGES-2:0], spi.sync_n};
      sclk_d <= sclk_s;
      sync_d <= sync_n_s;
    end
  end

  assign sclk_s    = sclk_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_q[SYNC_STAGES-1];
  assign sync_n_s  = sync_q[SYNC_STAGES-1];
  assign sclk_fall = sclk_d & ~sclk_s;
  assign sync_fall = sync_d & ~sync_n_s;
  assign sync_rise = ~sync_d & sync_n_s;

  assign cmd  = shift[23:20];
  assign data = shift[19:4];

  // NOTE: all state, registers and pulses use non-blocking assignments so every
  // branch below reads the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      shift       <= '0;
      input_reg   <= '0;
      dac_code    <= '0;
      ctrl_reg    <= '0;
      last_cmd    <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      dac_upd     <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      dac_upd     <= 1'b0;

      case (state)
        IDLE: begin
          if (sync_fall) begin
            state <= SHIFT;
            cnt   <= '0;
            shift <= '0;
          end
        end

        // Frame close wins over a coincident sclk edge: that edge is not counted.
        SHIFT: begin
          if (sync_rise) begin
            state <= DONE;
          end else if (sclk_fall) begin
            shift <= {shift[22:0], mosi_s};
            if (cnt != CNT_MAX) cnt <= cnt + 5'd1;
          end
        end

        DONE: begin
          state <= IDLE;
          if (cnt == FRAME_CNT) begin
            frame_valid <= 1'b1;
            last_cmd    <= cmd;
            case (cmd)
              CMD_WR_INPUT: input_reg <= data;
              CMD_LDAC: begin
                dac_code <= input_reg;
                dac_upd  <= 1'b1;
              end
              CMD_WR_UPDATE: begin
                input_reg <= data;
                dac_code  <= data;
                dac_upd   <= 1'b1;
              end
              CMD_WR_CTRL: begin
                if (shift[19]) begin
                  input_reg <= '0;
                  dac_code  <= '0;
                  ctrl_reg  <= '0;
                end else begin
                  ctrl_reg <= shift[19:14];
                end
              end
              default: ;
            endcase
          end else begin
            frame_err <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ad5683_spi_rx.sv
// Self-checking bench for ad5683_spi_rx: frames are driven on the SPI pins, a register
// model queues the expected outcome, and a monitor compares every output pulse.
module tb_ad5683_spi_rx;

  localparam int HALF = 8;  // sclk half period in clk cycles (sclk = clk/16)

  typedef struct {
    logic        valid;
    logic        err;
    logic        upd;
    logic [15:0] in_reg;
    logic [15:0] dac;
    logic [5:0]  ctrl;
    logic [3:0]  cmd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] input_reg, dac_code;
  logic [5:0]  ctrl_reg;
  logic [3:0]  last_cmd;
  logic        frame_valid, frame_err, dac_upd;

  ad5683_spi_rx_if spi ();

  ad5683_spi_rx dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .spi         (spi.slave),
    .input_reg   (input_reg),
    .dac_code    (dac_code),
    .ctrl_reg    (ctrl_reg),
    .last_cmd    (last_cmd),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .dac_upd     (dac_upd)
  );

  always #5 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb_q[$];

  logic [15:0] m_in, m_dac;
  logic [5:0]  m_ctrl;
  logic [3:0]  m_cmd;

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_frame(input logic [31:0] word, input int nbits, output exp_t e);
    logic [23:0] f;
    f       = word[23:0];
    e.valid = 1'b0;
    e.err   = 1'b0;
    e.upd   = 1'b0;
    if (nbits != 24) begin
      e.err = 1'b1;
    end else begin
      e.valid = 1'b1;
      m_cmd   = f[23:20];
      case (f[23:20])
        4'b0001: m_in = f[19:4];
        4'b0010: begin m_dac = m_in; e.upd = 1'b1; end
        4'b0011: begin m_in = f[19:4]; m_dac = f[19:4]; e.upd = 1'b1; end
        4'b0100: begin
          if (f[19]) begin m_in = '0; m_dac = '0; m_ctrl = '0; end
          else m_ctrl = f[19:14];
        end
        default: ;
      endcase
    end
    e.in_reg = m_in;
    e.dac    = m_dac;
    e.ctrl   = m_ctrl;
    e.cmd    = m_cmd;
  endtask

  task automatic drive_bits(input logic [31:0] word, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) begin
      spi.mosi = word[i];
      spi.sclk = 1'b1;
      wait_clks(HALF);
      spi.sclk = 1'b0;
      wait_clks(HALF);
    end
  endtask

  task automatic send_frame(input logic [31:0] word, input int nbits, input int gap);
    exp_t e;
    spi.sync_n = 1'b0;
    wait_clks(HALF);
    drive_bits(word, nbits);
    spi.sync_n = 1'b1;
    model_frame(word, nbits, e);
    sb_q.push_back(e);
    wait_clks(gap);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      wait_clks(1);
      n++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: %0d expected pulses never seen, required 0", tag, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    logic [43:0] obs;
    obs = {input_reg, dac_code, ctrl_reg, last_cmd, frame_valid, frame_err, dac_upd};
    checks++;
    if (obs !== 44'h0) begin
      failures++;
      $display("FAIL %s: outputs=%h required 0", tag, obs);
    end
  endtask

  task automatic check_val(input string tag, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h required %h", tag, act, req);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && (frame_valid | frame_err | dac_upd) !== 1'b0) begin
        checks++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_pulse: valid=%b err=%b upd=%b required none",
                   frame_valid, frame_err, dac_upd);
        end else begin
          e = sb_q.pop_front();
          if ({frame_valid, frame_err, dac_upd} !== {e.valid, e.err, e.upd}) begin
            failures++;
            $display("FAIL pulses: valid/err/upd=%b%b%b required %b%b%b",
                     frame_valid, frame_err, dac_upd, e.valid, e.err, e.upd);
          end
          checks++;
          if (input_reg !== e.in_reg) begin
            failures++;
            $display("FAIL input_reg: got %h required %h", input_reg, e.in_reg);
          end
          checks++;
          if (dac_code !== e.dac) begin
            failures++;
            $display("FAIL dac_code: got %h required %h", dac_code, e.dac);
          end
          checks++;
          if (ctrl_reg !== e.ctrl) begin
            failures++;
            $display("FAIL ctrl_reg: got %b required %b", ctrl_reg, e.ctrl);
          end
          checks++;
          if (last_cmd !== e.cmd) begin
            failures++;
            $display("FAIL last_cmd: got %h required %h", last_cmd, e.cmd);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    spi.sclk   = 1'b0;
    spi.mosi   = 1'b0;
    spi.sync_n = 1'b1;
    m_in = '0; m_dac = '0; m_ctrl = '0; m_cmd = '0;
    wait_clks(3);
    check_outputs_zero("reset_state");
    rst_n = 1'b1;
    wait_clks(5);
    check_outputs_zero("after_release");
  endtask

  task automatic test_write_update();
    send_frame({8'h0, 4'b0011, 16'hA5C3, 4'h0}, 24, 12);
    drain("write_update");
    check_val("t1_dac_code", dac_code, 16'hA5C3);
    check_val("t1_last_cmd", {12'h0, last_cmd}, 16'h0003);
  endtask

  task automatic test_ldac();
    send_frame({8'h0, 4'b0001, 16'h1234, 4'h0}, 24, 12);
    drain("write_input");
    check_val("t2_dac_held", dac_code, 16'hA5C3);
    send_frame({8'h0, 4'b0010, 16'hFFFF, 4'hF}, 24, 12);
    drain("ldac");
    check_val("t2_dac_loaded", dac_code, 16'h1234);
  endtask

  task automatic test_bad_length();
    send_frame({9'h0, 23'h7FFFFF}, 23, 12);
    send_frame({7'h0, 4'b0011, 16'hDEAD, 5'h1F}, 25, 12);
    drain("bad_length");
    check_val("t3_dac_kept", dac_code, 16'h1234);
    check_val("t3_cmd_kept", {12'h0, last_cmd}, 16'h0002);
  endtask

  task automatic test_ctrl();
    send_frame({8'h0, 4'b0100, 6'b011010, 14'h0}, 24, 12);
    drain("ctrl_write");
    check_val("t4_ctrl", {10'h0, ctrl_reg}, 16'h001A);
    send_frame({8'h0, 4'b0100, 1'b1, 19'h0}, 24, 12);
    drain("soft_reset");
    check_val("t4_sw_rst", {input_reg | dac_code | {10'h0, ctrl_reg}}, 16'h0000);
  endtask

  task automatic test_mid_frame_reset();
    logic [31:0] w;
    w = {8'h0, 4'b0011, 16'hBEEF, 4'h0};
    spi.sync_n = 1'b0;
    wait_clks(HALF);
    drive_bits(w >> 12, 12);
    rst_n = 1'b0;
    m_in = '0; m_dac = '0; m_ctrl = '0; m_cmd = '0;
    wait_clks(2);
    check_outputs_zero("reset_mid_frame");
    spi.sync_n = 1'b1;
    wait_clks(4);
    check_outputs_zero("reset_hold");
    rst_n = 1'b1;
    wait_clks(10);
    check_outputs_zero("reset_no_pulse");
    send_frame({8'h0, 4'b0011, 16'h00FF, 4'h0}, 24, 12);
    drain("post_reset");
    check_val("t5_dac", dac_code, 16'h00FF);
  endtask

  task automatic test_back_to_back();
    send_frame({8'h0, 4'b0011, 16'h0001, 4'h0}, 24, 3);
    send_frame({8'h0, 4'b0011, 16'h0002, 4'h0}, 24, 12);
    drain("back_to_back");
    check_val("t6_dac", dac_code, 16'h0002);
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_write_update();
    test_ldac();
    test_bad_length();
    test_ctrl();
    test_mid_frame_reset();
    test_back_to_back();
    wait_clks(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
